// File: rtl/saes_pkg.sv
// Shared definitions for the simplified-AES key schedule: S-box, round
// constants and the expansion FSM state type.
package saes_pkg;

    localparam int KEY_W = 16;
    localparam int BYTE_W = KEY_W / 2;

    localparam logic [BYTE_W-1:0] RCON1 = 8'h80;
    localparam logic [BYTE_W-1:0] RCON2 = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXP1  = 2'd1,
        ST_EXP2  = 2'd2,
        ST_READY = 2'd3
    } ks_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        logic [3:0] s;
        case (n)
            4'h0: s = 4'h9;
            4'h1: s = 4'h4;
            4'h2: s = 4'hA;
            4'h3: s = 4'hB;
            4'h4: s = 4'hD;
            4'h5: s = 4'h1;
            4'h6: s = 4'h8;
            4'h7: s = 4'h5;
            4'h8: s = 4'h6;
            4'h9: s = 4'h2;
            4'hA: s = 4'h0;
            4'hB: s = 4'h3;
            4'hC: s = 4'hC;
            4'hD: s = 4'hE;
            4'hE: s = 4'hF;
            default: s = 4'h7;
        endcase
        return s;
    endfunction

    function automatic logic [BYTE_W-1:0] rot_nib(input logic [BYTE_W-1:0] b);
        return {b[3:0], b[7:4]};
    endfunction

endpackage

// File: rtl/sub_nib.sv
// Combinational 4-bit S-box lookup used by the key expansion datapath.
module sub_nib
    import saes_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = sbox4(nib_i);

endmodule

// File: rtl/ark_keysched.sv
// Key expansion (K0..K2 over three cycles) plus AddRoundKey stage with a
// one-entry registered output and ready/valid flow control.
module ark_keysched
    import saes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_load,
    input  logic [KEY_W-1:0]  state_in,
    input  logic [1:0]        in_round,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [KEY_W-1:0]  out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              keys_valid
);

    ks_state_e         state_q, state_d;
    logic [KEY_W-1:0]  k0_q, k0_d;
    logic [KEY_W-1:0]  k1_q, k1_d;
    logic [KEY_W-1:0]  k2_q, k2_d;

    logic [BYTE_W-1:0] exp_src;
    logic [BYTE_W-1:0] exp_base;
    logic [BYTE_W-1:0] exp_rcon;
    logic [BYTE_W-1:0] exp_rot;
    logic [BYTE_W-1:0] exp_sub;
    logic [BYTE_W-1:0] w_even;
    logic [BYTE_W-1:0] w_odd;

    logic [KEY_W-1:0]  out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic              out_valid_q, out_valid_d;
    logic [KEY_W-1:0]  round_key;
    logic              xfer;

    // One shared g-function: EXP1 works on (w0, w1), EXP2 on (w2, w3).
    always_comb begin
        if (state_q == ST_EXP2) begin
            exp_src  = k1_q[BYTE_W-1:0];
            exp_base = k1_q[KEY_W-1:BYTE_W];
            exp_rcon = RCON2;
        end else begin
            exp_src  = k0_q[BYTE_W-1:0];
            exp_base = k0_q[KEY_W-1:BYTE_W];
            exp_rcon = RCON1;
        end
    end

    assign exp_rot = rot_nib(exp_src);

    sub_nib u_sub_hi (
        .nib_i (exp_rot[7:4]),
        .nib_o (exp_sub[7:4])
    );

    sub_nib u_sub_lo (
        .nib_i (exp_rot[3:0]),
        .nib_o (exp_sub[3:0])
    );

    assign w_even = exp_base ^ exp_rcon ^ exp_sub;
    assign w_odd  = w_even ^ exp_src;

    // A new key always restarts at EXP1; stale K1/K2 are hidden by keys_valid.
    always_comb begin
        state_d = state_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        if (key_load) begin
            state_d = ST_EXP1;
            k0_d    = key_in;
        end else begin
            case (state_q)
                ST_EXP1: begin
                    k1_d    = {w_even, w_odd};
                    state_d = ST_EXP2;
                end
                ST_EXP2: begin
                    k2_d    = {w_even, w_odd};
                    state_d = ST_READY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
        end
    end

    assign keys_valid = (state_q == ST_READY);
    assign in_ready   = keys_valid && (!out_valid_q || out_ready);
    assign xfer       = in_valid && in_ready;

    always_comb begin
        case (in_round)
            2'd0:    round_key = k0_q;
            2'd1:    round_key = k1_q;
            2'd2:    round_key = k2_q;
            default: round_key = '0;
        endcase
    end

    // Output slot: load on transfer, drain on handshake, otherwise hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = state_in ^ round_key;
            out_err_d   = (in_round == 2'd3);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ark_keysched.sv
// Directed bench for ark_keysched: key expansion timing, round-key XOR
// vectors, backpressure, restart and reset corner cases.
module tb_ark_keysched;

    logic        clk;
    logic        rst_n;
    logic [15:0] key_in;
    logic        key_load;
    logic [15:0] state_in;
    logic [1:0]  in_round;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        keys_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] st;
        logic [1:0]  rnd;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs_a[10];
    vec_t vecs_b[4];
    vec_t vecs_c[3];

    ark_keysched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_load   (key_load),
        .state_in   (state_in),
        .in_round   (in_round),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .keys_valid (keys_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [15:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_out_data"}, out_data, 16'h0000);
        chk({tag, "_out_err"}, {15'd0, out_err}, 16'd0);
        chk({tag, "_keys_valid"}, {15'd0, keys_valid}, 16'd0);
        chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        state_in = v.st;
        in_round = v.rnd;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        step();
        chk({tag, "_data"}, out_data, v.exp_d);
        chk({tag, "_err"}, {15'd0, out_err}, {15'd0, v.exp_e});
        chk({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
    endtask

    initial begin
        // key 4AF5: K0=4AF5 K1=DD28 K2=87AF
        vecs_a[0] = '{16'h1234, 2'd0, 16'h58C1, 1'b0};
        vecs_a[1] = '{16'h1234, 2'd1, 16'hCF1C, 1'b0};
        vecs_a[2] = '{16'h1234, 2'd2, 16'h959B, 1'b0};
        vecs_a[3] = '{16'hBEEF, 2'd3, 16'hBEEF, 1'b1};
        vecs_a[4] = '{16'h0000, 2'd0, 16'h4AF5, 1'b0};
        vecs_a[5] = '{16'h0000, 2'd1, 16'hDD28, 1'b0};
        vecs_a[6] = '{16'h0000, 2'd2, 16'h87AF, 1'b0};
        vecs_a[7] = '{16'hFFFF, 2'd0, 16'hB50A, 1'b0};
        vecs_a[8] = '{16'hFFFF, 2'd2, 16'h7850, 1'b0};
        vecs_a[9] = '{16'hA5A5, 2'd1, 16'h788D, 1'b0};
        // key 0000: K0=0000 K1=1919 K2=0D14
        vecs_b[0] = '{16'h0000, 2'd0, 16'h0000, 1'b0};
        vecs_b[1] = '{16'h0000, 2'd1, 16'h1919, 1'b0};
        vecs_b[2] = '{16'h0000, 2'd2, 16'h0D14, 1'b0};
        vecs_b[3] = '{16'h0000, 2'd3, 16'h0000, 1'b1};
        // key 3A7C: K0=3A7C K1=7F03 K2=F6F5
        vecs_c[0] = '{16'h0000, 2'd0, 16'h3A7C, 1'b0};
        vecs_c[1] = '{16'h0000, 2'd1, 16'h7F03, 1'b0};
        vecs_c[2] = '{16'h0000, 2'd2, 16'hF6F5, 1'b0};

        rst_n     = 1'b0;
        key_in    = 16'h0;
        key_load  = 1'b0;
        state_in  = 16'h0;
        in_round  = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk_reset_outputs("rst");

        rst_n = 1'b1;
        step();
        chk("idle_in_ready", {15'd0, in_ready}, 16'd0);

        load_key(16'h4AF5);
        chk("kv_after_load", {15'd0, keys_valid}, 16'd0);
        chk("exp_in_ready", {15'd0, in_ready}, 16'd0);
        step();
        chk("kv_exp2", {15'd0, keys_valid}, 16'd0);
        step();
        chk("kv_rise", {15'd0, keys_valid}, 16'd1);

        for (int i = 0; i < 10; i++) run_vec($sformatf("vecA%0d", i), vecs_a[i]);

        // Backpressure: the last vector's result must hold for 4 cycles.
        out_ready = 1'b0;
        state_in  = 16'h1111;
        in_round  = 2'd0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_in_ready%0d", k), {15'd0, in_ready}, 16'd0);
            step();
            chk($sformatf("bp_hold%0d", k), out_data, 16'h788D);
            chk($sformatf("bp_valid%0d", k), {15'd0, out_valid}, 16'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {15'd0, in_ready}, 16'd1);
        step();
        chk("release_data", out_data, 16'h5BE4);
        in_valid = 1'b0;
        step();
        chk("drain_valid", {15'd0, out_valid}, 16'd0);

        // Pending output survives a new key; restart during EXP2.
        out_ready = 1'b0;
        state_in  = 16'h0000;
        in_round  = 2'd1;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pend_data", out_data, 16'hDD28);
        load_key(16'h4AF5);
        chk("pend_hold_data", out_data, 16'hDD28);
        chk("pend_hold_valid", {15'd0, out_valid}, 16'd1);
        chk("reload_kv_low", {15'd0, keys_valid}, 16'd0);
        step();
        load_key(16'h0000);
        chk("restart_kv0", {15'd0, keys_valid}, 16'd0);
        step();
        chk("restart_kv1", {15'd0, keys_valid}, 16'd0);
        step();
        chk("restart_kv2", {15'd0, keys_valid}, 16'd1);
        chk("restart_pend", out_data, 16'hDD28);
        out_ready = 1'b1;
        step();
        chk("restart_drain", {15'd0, out_valid}, 16'd0);
        for (int i = 0; i < 4; i++) run_vec($sformatf("vecB%0d", i), vecs_b[i]);
        in_valid = 1'b0;
        step();

        // Reset in EXP1 with a pending output, key_load and in_valid all active.
        out_ready = 1'b0;
        state_in  = 16'h1234;
        in_round  = 2'd0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pre_rst_data", out_data, 16'h1234);
        load_key(16'h4AF5);
        rst_n    = 1'b0;
        key_load = 1'b1;
        in_valid = 1'b1;
        step();
        chk_reset_outputs("rst_exp1");
        rst_n     = 1'b0;
        rst_n     = 1'b1;
        key_load  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("post_rst_ready%0d", k), {15'd0, in_ready}, 16'd0);
            step();
            chk($sformatf("post_rst_valid%0d", k), {15'd0, out_valid}, 16'd0);
        end
        in_valid = 1'b0;
        load_key(16'h3A7C);
        step();
        step();
        chk("post_rst_kv", {15'd0, keys_valid}, 16'd1);
        for (int i = 0; i < 3; i++) run_vec($sformatf("vecC%0d", i), vecs_c[i]);
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ark_keysched.md
ARK_KEYSCHED -- requirements
Module: ark_keysched

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-003: key_in  input  16  cipher key {w0[15:8], w1[7:0]}, sampled when key_load=1.
REQ-004: key_load  input  1  one-cycle pulse; starts key expansion from key_in.
REQ-005: state_in  input  16  state nibbles {n00,n01,n10,n11}, the MixColumns output or the initial plaintext.
REQ-006: in_round  input  2  round-key select: 0=K0, 1=K1, 2=K2, 3=illegal.
REQ-007: in_valid  input  1  state_in/in_round valid.
REQ-008: in_ready  output  1  block accepts input this cycle.
REQ-009: out_data  output  16  state_in XOR selected round key, registered.
REQ-010: out_err  output  1  set with out_data when the accepted in_round was 3.
REQ-011: out_valid  output  1  out_data/out_err valid.
REQ-012: out_ready  input  1  downstream accepts output.
REQ-013: keys_valid  output  1  K0..K2 hold a completed expansion.

Function
REQ-014: FSM states IDLE, EXP1, EXP2, READY; IDLE -> EXP1 on key_load; EXP1 -> EXP2; EXP2 -> READY; READY -> EXP1 on key_load.
REQ-015: On key_load the block SHALL register w0=key_in[15:8] and w1=key_in[7:0], giving K0={w0,w1} at the next edge.
REQ-016: EXP1 SHALL compute w2 = w0 ^ 8'h80 ^ SubNib(RotNib(w1)) and w3 = w2 ^ w1, registering K1={w2,w3}.
REQ-017: EXP2 SHALL compute w4 = w2 ^ 8'h30 ^ SubNib(RotNib(w3)) and w5 = w4 ^ w3, registering K2={w4,w5}.
REQ-018: RotNib SHALL swap the two nibbles of a byte; SubNib SHALL apply the S-box 0..F -> 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7 to each nibble.
REQ-019: keys_valid SHALL go low the cycle after key_load and go high on entry to READY, which is 3 cycles after key_load.
REQ-020: key_load during EXP1/EXP2 SHALL restart expansion at EXP1 with the new key; the partial expansion SHALL be discarded.
REQ-021: in_ready SHALL equal keys_valid AND (NOT out_valid OR out_ready).
REQ-022: A transfer occurs when in_valid AND in_ready; out_data SHALL be registered with 1-cycle latency, and full throughput (1/cycle) SHALL be sustained while out_ready=1.
REQ-023: For in_round 3, out_data SHALL equal state_in unchanged and out_err SHALL be 1; otherwise out_err SHALL be 0.
REQ-024: While out_valid=1 and out_ready=0, out_data and out_err SHALL hold stable.
REQ-025: out_valid SHALL clear after an output handshake with no simultaneous input transfer.
REQ-026: A pending output already registered when key_load arrives SHALL be retained unchanged, since it was computed with the old key.

Reset
REQ-027: When rst_n=0 at a clk edge, FSM SHALL be IDLE, K0..K2=16'h0000, keys_valid=0, out_valid=0, out_data=16'h0000, out_err=0.
REQ-028: Reset SHALL take priority over key_load and in_valid, including mid-expansion.
REQ-029: in_ready SHALL be 0 during reset and until the first expansion completes.

Structure
REQ-030: Package saes_pkg SHALL hold the S-box table/function, RCON1=8'h80, RCON2=8'h30, and the FSM state enum, shared with the SubNibbles stage.
REQ-031: Sub-module sub_nib (4-bit combinational S-box) SHALL be instantiated for the RotNib/SubNib paths.

Verification
REQ-032: Key 16'h4AF5 loaded -> keys_valid=1 after 3 cycles with K0=4AF5, K1=DD28, K2=87AF.
REQ-033: state_in 16'h1234 at rounds 0,1,2 back-to-back with out_ready=1 -> out_data 58C1, CF1C, 959B on consecutive cycles.
REQ-034: in_round=3 with state_in 16'hBEEF -> out_data=BEEF, out_err=1.
REQ-035: out_ready held 0 for 4 cycles with out_valid=1 -> in_ready=0 and out_data stable; release -> the next input is accepted in the same cycle.
REQ-036: key_load 16'h4AF5 then, in EXP2, key_load 16'h0000 -> final keys are those of 0000 and keys_valid rises 3 cycles after the second load.
REQ-037: rst_n=0 in EXP1 -> all outputs at their reset values next cycle and in_ready=0 until a new key_load completes.
